// File: rtl/lcd_pkg.sv
// Shared constants for the SPI LCD frame feeder: word width, panel opcodes and FSM state encoding.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;

  localparam logic [7:0] SLPOUT       = 8'h11;
  localparam logic [7:0] COLMOD       = 8'h3A;
  localparam logic [7:0] MADCTL       = 8'h36;
  localparam logic [7:0] CASET        = 8'h2A;
  localparam logic [7:0] RASET        = 8'h2B;
  localparam logic [7:0] DISPON       = 8'h29;
  localparam logic [7:0] RAMWR        = 8'h2C;
  localparam logic [7:0] COLMOD_18BPP = 8'h66;

  typedef enum logic [2:0] {
    ST_RST_LOW   = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_INIT      = 3'd2,
    ST_SLP_WAIT  = 3'd3,
    ST_PIXEL     = 3'd4,
    ST_FRAME_END = 3'd5
  } lcd_state_e;

  // DCX=0 marks a command byte, DCX=1 a parameter/pixel byte.
  function automatic logic [LCD_WORD_W-1:0] cmd_word(input logic [7:0] b);
    return {1'b0, b};
  endfunction

  function automatic logic [LCD_WORD_W-1:0] dat_word(input logic [7:0] b);
    return {1'b1, b};
  endfunction

endpackage

// File: rtl/lcd_frame_feeder_if.sv
// Word handshake between the frame feeder (master) and the SPI serializer (slave).
interface lcd_frame_feeder_if;
  import lcd_pkg::*;

  logic [LCD_WORD_W-1:0] WORD_DATA;
  logic                  WORD_VALID;
  logic                  WORD_READY;

  modport master (output WORD_DATA, output WORD_VALID, input WORD_READY);
  modport slave  (input WORD_DATA, input WORD_VALID, output WORD_READY);

endinterface

// File: rtl/lcd_init_rom.sv
// Panel init command list as a combinational lookup; window size follows H_RES/V_RES.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int H_RES = 128,
  parameter int V_RES = 160
) (
  input  logic [4:0]            index,
  output logic [LCD_WORD_W-1:0] word
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves word unassigned (no latch).
    word = '0;
    case (index)
      5'd0:    word = cmd_word(SLPOUT);
      5'd1:    word = cmd_word(COLMOD);
      5'd2:    word = dat_word(COLMOD_18BPP);
      5'd3:    word = cmd_word(MADCTL);
      5'd4:    word = dat_word(8'h00);
      5'd5:    word = cmd_word(CASET);
      5'd6:    word = dat_word(8'h00);
      5'd7:    word = dat_word(8'h00);
      5'd8:    word = dat_word(8'h00);
      5'd9:    word = dat_word(8'(H_RES - 1));
      5'd10:   word = cmd_word(RASET);
      5'd11:   word = dat_word(8'h00);
      5'd12:   word = dat_word(8'h00);
      5'd13:   word = dat_word(8'h00);
      5'd14:   word = dat_word(8'(V_RES - 1));
      5'd15:   word = cmd_word(DISPON);
      5'd16:   word = cmd_word(RAMWR);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/lcd_frame_feeder.sv
// Panel reset, init sequence and RGB666 colour-bar frames as 9-bit {DCX,byte} words.
// Define LCD_FRAME_REPEAT_EN to stream frames forever (RAMWR between frames); otherwise one frame.
module lcd_frame_feeder
  import lcd_pkg::*;
#(
  parameter int H_RES        = 128,
  parameter int V_RES        = 160,
  parameter int RST_LOW_CYC  = 160,
  parameter int RST_WAIT_CYC = 1920000,
  parameter int SLP_WAIT_CYC = 1920000,
  parameter int BAR_W        = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic                RESX,
  lcd_frame_feeder_if.master  wbus,
  output logic                INIT_DONE,
  output logic                FRAME_DONE
);

  localparam int MAX_A    = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_WAIT = (MAX_A > SLP_WAIT_CYC) ? MAX_A : SLP_WAIT_CYC;
  localparam int CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int BAR_SH   = $clog2(BAR_W);

  localparam logic [2:0] S_RST_LOW   = ST_RST_LOW;
  localparam logic [2:0] S_RST_WAIT  = ST_RST_WAIT;
  localparam logic [2:0] S_INIT      = ST_INIT;
  localparam logic [2:0] S_SLP_WAIT  = ST_SLP_WAIT;
  localparam logic [2:0] S_PIXEL     = ST_PIXEL;
  localparam logic [2:0] S_FRAME_END = ST_FRAME_END;

  localparam logic [4:0] INIT_LAST = 5'd16;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [4:0]            idx;
  logic [7:0]            x, y;
  logic [1:0]            sub;
  logic                  valid;
  logic                  fire;
  logic [7:0]            xbar;
  logic [2:0]            bar;
  logic                  chan_bit;
  logic [LCD_WORD_W-1:0] rom_word;
  logic [LCD_WORD_W-1:0] word_next;

  lcd_init_rom #(.H_RES(H_RES), .V_RES(V_RES)) u_rom (
    .index (idx),
    .word  (rom_word)
  );

  assign fire = valid && wbus.WORD_READY;
  assign xbar = x >> BAR_SH;
  assign bar  = xbar[2:0];

  // Sub-byte index selects the channel: R=bar[2], G=bar[1], B=bar[0].
  always_comb begin
    chan_bit = bar[0];
    case (sub)
      2'd0:    chan_bit = bar[2];
      2'd1:    chan_bit = bar[1];
      default: chan_bit = bar[0];
    endcase
  end

  // The presented word is a pure function of held state, so it cannot change while stalled.
  always_comb begin
    word_next = '0;
    case (state)
      S_INIT:      word_next = rom_word;
      S_PIXEL:     word_next = dat_word({{6{chan_bit}}, 2'b00});
      S_FRAME_END: word_next = cmd_word(RAMWR);
      default:     word_next = '0;
    endcase
  end

  assign wbus.WORD_DATA  = valid ? word_next : '0;
  assign wbus.WORD_VALID = valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_RST_LOW;
      cnt        <= '0;
      idx        <= '0;
      x          <= '0;
      y          <= '0;
      sub        <= '0;
      valid      <= 1'b0;
      RESX       <= 1'b0;
      INIT_DONE  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      FRAME_DONE <= 1'b0;
      case (state)
        S_RST_LOW: begin
          if (cnt == CNT_W'(RST_LOW_CYC - 1)) begin
            state <= S_RST_WAIT;
            cnt   <= '0;
            RESX  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RST_WAIT: begin
          if (cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
            state <= S_INIT;
            cnt   <= '0;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_INIT: begin
          if (fire) begin
            if (idx == 5'd0) begin
              state <= S_SLP_WAIT;
              valid <= 1'b0;
              idx   <= 5'd1;
            end else if (idx == INIT_LAST) begin
              state     <= S_PIXEL;
              INIT_DONE <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        S_SLP_WAIT: begin
          if (cnt == CNT_W'(SLP_WAIT_CYC - 1)) begin
            state <= S_INIT;
            cnt   <= '0;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PIXEL: begin
          if (fire) begin
            if (sub != 2'd2) begin
              sub <= sub + 2'd1;
            end else begin
              sub <= 2'd0;
              if (x == 8'(H_RES - 1)) begin
                x <= 8'd0;
                if (y == 8'(V_RES - 1)) begin
                  y          <= 8'd0;
                  FRAME_DONE <= 1'b1;
                  state      <= S_FRAME_END;
`ifndef LCD_FRAME_REPEAT_EN
                  valid      <= 1'b0;
`endif
                end else begin
                  y <= y + 8'd1;
                end
              end else begin
                x <= x + 8'd1;
              end
            end
          end
        end
        S_FRAME_END: begin
`ifdef LCD_FRAME_REPEAT_EN
          if (fire) state <= S_PIXEL;
`else
          state <= S_FRAME_END;
`endif
        end
        default: state <= S_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Self-checking bench for lcd_frame_feeder: a word-list model drives a per-cycle compare process.
module tb_lcd_frame_feeder;

  localparam int H_RES        = 4;
  localparam int V_RES        = 2;
  localparam int BAR_W        = 2;
  localparam int RST_LOW_CYC  = 4;
  localparam int RST_WAIT_CYC = 8;
  localparam int SLP_WAIT_CYC = 8;
`ifdef LCD_FRAME_REPEAT_EN
  localparam int N_FRAMES = 2;
`else
  localparam int N_FRAMES = 1;
`endif

  typedef struct {
    logic [8:0] w;
    bit         last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic RESX, INIT_DONE, FRAME_DONE;

  lcd_frame_feeder_if lcd_bus ();

  lcd_frame_feeder #(
    .H_RES(H_RES), .V_RES(V_RES), .RST_LOW_CYC(RST_LOW_CYC),
    .RST_WAIT_CYC(RST_WAIT_CYC), .SLP_WAIT_CYC(SLP_WAIT_CYC), .BAR_W(BAR_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RESX       (RESX),
    .wbus       (lcd_bus),
    .INIT_DONE  (INIT_DONE),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   pulses = 0;
  int   stalls = 0;
  bit   rand_ready = 1'b0;
  bit   hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected pixel word from the bar rule: bar=(x/BAR_W)%8, channel c picks bit 2-c.
  function automatic logic [8:0] px_word(input int px, input int c);
    int bar;
    bar = (px / BAR_W) % 8;
    return ((bar >> (2 - c)) & 1) != 0 ? 9'h1FC : 9'h100;
  endfunction

  task automatic push_frame();
    for (int yy = 0; yy < V_RES; yy++)
      for (int xx = 0; xx < H_RES; xx++)
        for (int c = 0; c < 3; c++) begin
          exp_t e;
          e.w    = px_word(xx, c);
          e.last = (yy == V_RES - 1) && (xx == H_RES - 1) && (c == 2);
          exp_q.push_back(e);
        end
  endtask

  task automatic fill_all();
    logic [8:0] tbl [17];
    exp_t e;
    tbl = '{9'h011, 9'h03A, 9'h166, 9'h036, 9'h100, 9'h02A, 9'h100, 9'h100, 9'h100,
            9'h100 | 9'(H_RES - 1), 9'h02B, 9'h100, 9'h100, 9'h100,
            9'h100 | 9'(V_RES - 1), 9'h029, 9'h02C};
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      e.w = tbl[i];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    push_frame();
`ifdef LCD_FRAME_REPEAT_EN
    e.w = 9'h02C;
    e.last = 1'b0;
    exp_q.push_back(e);
    push_frame();
`endif
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge CLK);
      n++;
    end
`ifdef LCD_FRAME_REPEAT_EN
    hold = 1'b1;
`endif
    check("drain_words_left", exp_q.size(), 0);
  endtask

  task automatic measure_resx_low(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!RESX && n < 50);
    check(name, n, RST_LOW_CYC);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resx"},       RESX, 0);
    check({tag, "_valid"},      lcd_bus.WORD_VALID, 0);
    check({tag, "_data"},       lcd_bus.WORD_DATA, 0);
    check({tag, "_init_done"},  INIT_DONE, 0);
    check({tag, "_frame_done"}, FRAME_DONE, 0);
  endtask

  // READY source: held high, 30% random, or forced low to freeze the DUT.
  initial begin
    lcd_bus.WORD_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (hold)            lcd_bus.WORD_READY = 1'b0;
      else if (rand_ready) lcd_bus.WORD_READY = ($urandom_range(0, 9) < 3);
      else                 lcd_bus.WORD_READY = 1'b1;
    end
  end

  // Compare process: every transfer against the model, hold-while-stalled, FRAME_DONE timing.
  bit         stall_prev = 1'b0;
  bit         fd_pending = 1'b0;
  logic [8:0] prev_data  = '0;

  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      stall_prev = 1'b0;
      fd_pending = 1'b0;
    end else begin
      check("frame_done_timing", FRAME_DONE, fd_pending);
      if (FRAME_DONE) pulses++;
      fd_pending = 1'b0;
      if (stall_prev) begin
        stalls++;
        check("stall_valid_held", lcd_bus.WORD_VALID, 1);
        check("stall_data_held", lcd_bus.WORD_DATA, prev_data);
      end
      if (lcd_bus.WORD_VALID && lcd_bus.WORD_READY) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word_data", lcd_bus.WORD_DATA, e.w);
          fd_pending = e.last;
        end
      end
      stall_prev = lcd_bus.WORD_VALID && !lcd_bus.WORD_READY;
      prev_data  = lcd_bus.WORD_DATA;
    end
  end

  initial begin
    int n;
    int base;

    // Reset state and model pins
    repeat (3) tick();
    check_reset_outputs("reset");
    fill_all();
    check("model_caset_end", exp_q[9].w, 9'h103);
    check("model_raset_end", exp_q[14].w, 9'h101);
    check("model_x2_r", exp_q[17 + 6].w, 9'h100);
    check("model_x2_b", exp_q[17 + 8].w, 9'h1FC);
    check("model_last_flag", exp_q[17 + 23].last, 1);

    // Power-up timing and first word
    RST_N = 1'b1;
    measure_resx_low("resx_low_cycles");
    n = 0;
    while (!lcd_bus.WORD_VALID && n < 100) begin tick(); n++; end
    check("valid_after_resx", n, RST_WAIT_CYC);
    check("first_word", lcd_bus.WORD_DATA, 9'h011);

    // SLPOUT gap
    n = 0;
    while (lcd_bus.WORD_VALID && n < 100) begin tick(); n++; end
    n = 0;
    while (!lcd_bus.WORD_VALID && n < 100) begin tick(); n++; end
    check("slpout_gap", n, SLP_WAIT_CYC);

    n = 0;
    while (!INIT_DONE && n < 300) begin tick(); n++; end
    check("init_done", INIT_DONE, 1);

    // Full frame(s) at READY=1
    wait_drain(2000);
    repeat (2) @(negedge CLK);
    check("frame_pulses", pulses, N_FRAMES);

`ifdef LCD_FRAME_REPEAT_EN
    tick();
    check("repeat_valid", lcd_bus.WORD_VALID, 1);
    check("repeat_ramwr", lcd_bus.WORD_DATA, 9'h02C);
`else
    n = 0;
    repeat (100) begin tick(); if (lcd_bus.WORD_VALID) n++; end
    check("done_valid_cycles", n, 0);
    check("done_init_done", INIT_DONE, 1);
    check("done_resx", RESX, 1);
`endif

    // Mid-frame abort
    tick();
    RST_N = 1'b0;
    hold  = 1'b0;
    repeat (2) tick();
    fill_all();
    RST_N = 1'b1;
    n = 0;
    while (!INIT_DONE && n < 300) begin tick(); n++; end
    repeat (7) tick();
    check("midframe_valid", lcd_bus.WORD_VALID, 1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();

    // Replay under random READY
    base = pulses;
    repeat (2) tick();
    rand_ready = 1'b1;
    fill_all();
    RST_N = 1'b1;
    measure_resx_low("replay_resx_low");
    wait_drain(5000);
    repeat (2) @(negedge CLK);
    check("replay_frame_pulses", pulses - base, N_FRAMES);
    check("replay_stalls_seen", stalls > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
